// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg
// Shared definitions for the PC sequencer: the FSM state encoding, the
// default parameter values and a helper for sizing the table index.
package pc_seq_ctrl_pkg;

    // Default PC/address width, jump-table depth and retired-counter width.
    localparam int D_DEF  = 12;
    localparam int N_DEF  = 16;
    localparam int CW_DEF = 16;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a table index; a single-entry table still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if
// Control/status bundle of the PC sequencer.
//   master : the controlling agent (drives start/stall/jump/halt and the
//            jump-table write port, observes pc/busy/done/miss/icount)
//   slave  : the sequencer itself
interface pc_seq_ctrl_if
    import pc_seq_ctrl_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) ();

    localparam int IW = idx_width(N);

    logic          start;
    logic [D-1:0]  start_pc;
    logic          stall;
    logic          jump;
    logic          halt;
    logic          tbl_we;
    logic [IW-1:0] tbl_idx;
    logic [D-1:0]  tbl_addr;
    logic [D-1:0]  tbl_off;
    logic [D-1:0]  pc;
    logic          busy;
    logic          done;
    logic          miss;
    logic [CW-1:0] icount;

    modport master (
        output start, start_pc, stall, jump, halt,
        output tbl_we, tbl_idx, tbl_addr, tbl_off,
        input  pc, busy, done, miss, icount
    );

    modport slave (
        input  start, start_pc, stall, jump, halt,
        input  tbl_we, tbl_idx, tbl_addr, tbl_off,
        output pc, busy, done, miss, icount
    );

endinterface

// File: rtl/pc_jump_lookup.sv
// pc_jump_lookup
// Combinational jump-table search. An entry hits when it is valid and its
// address equals pc; the lowest-index hit supplies the offset.
//   pc        : current program counter
//   tbl_addr  : per-entry owning instruction address
//   tbl_off   : per-entry two's-complement offset
//   tbl_valid : per-entry valid bit
//   hit       : at least one entry matched
//   jump_pc   : pc + offset of the winning entry, modulo 2^D
module pc_jump_lookup
    import pc_seq_ctrl_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int N = N_DEF
) (
    input  logic [D-1:0] pc,
    input  logic [D-1:0] tbl_addr [N],
    input  logic [D-1:0] tbl_off  [N],
    input  logic [N-1:0] tbl_valid,
    output logic         hit,
    output logic [D-1:0] jump_pc
);

    logic [N-1:0] match_s;
    logic [D-1:0] sel_off_s;

    // Per-entry match, then a priority pick: scanning from the top index
    // down lets the lowest matching index overwrite everything above it.
    always_comb begin
        match_s   = {N{1'b0}};
        sel_off_s = {D{1'b0}};
        for (int i = 0; i < N; i++) begin
            match_s[i] = tbl_valid[i] && (tbl_addr[i] == pc);
        end
        for (int i = N - 1; i >= 0; i--) begin
            sel_off_s = match_s[i] ? tbl_off[i] : sel_off_s;
        end
        hit     = |match_s;
        // Unsigned D-bit add performs the two's-complement wrap.
        jump_pc = pc + sel_off_s;
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Program-counter sequencer with a flop-based jump table.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pc_seq_ctrl_if.slave
//           start/start_pc - begin execution at start_pc (level)
//           stall          - freeze pc and counter this cycle
//           jump/halt      - current instruction is a taken jump / the last
//           tbl_*          - jump-table write port (ignored while running)
//           pc/busy/done   - program counter and FSM status
//           miss           - sticky: a jump found no table entry
//           icount         - saturating retired-instruction count
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    pc_seq_ctrl_if.slave  bus
);

    localparam int IW = idx_width(N);

    // Saturating increment of the retired-instruction counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : (v + CW'(1));
    endfunction

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] icount_q, icount_d;
    logic          miss_q, miss_d;
    logic          busy_q, done_q;

    logic [D-1:0]  tbl_addr_q [N];
    logic [D-1:0]  tbl_addr_d [N];
    logic [D-1:0]  tbl_off_q  [N];
    logic [D-1:0]  tbl_off_d  [N];
    logic [N-1:0]  tbl_valid_q, tbl_valid_d;

    logic          tbl_wr_s;
    logic          hit_s;
    logic [D-1:0]  jump_pc_s;

    pc_jump_lookup #(
        .D (D),
        .N (N)
    ) u_lookup (
        .pc        (pc_q),
        .tbl_addr  (tbl_addr_q),
        .tbl_off   (tbl_off_q),
        .tbl_valid (tbl_valid_q),
        .hit       (hit_s),
        .jump_pc   (jump_pc_s)
    );

    // Next-state logic for the FSM, pc, counter and sticky miss flag.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        miss_d   = miss_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    pc_d     = bus.start_pc;
                    icount_d = {CW{1'b0}};
                    miss_d   = 1'b0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Priority: stall, then halt, then jump, then sequential.
                if (bus.stall) begin
                    state_d = ST_RUN;
                end else if (bus.halt) begin
                    state_d  = ST_DONE;
                    icount_d = sat_inc(icount_q);
                end else if (bus.jump) begin
                    if (hit_s) begin
                        pc_d     = jump_pc_s;
                        icount_d = sat_inc(icount_q);
                    end else begin
                        // Unmapped jump: stop without retiring it.
                        miss_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    pc_d     = pc_q + D'(1);
                    icount_d = sat_inc(icount_q);
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Jump-table write port; writes are locked out while running. A write
    // coinciding with IDLE->RUN is accepted since state_q is still IDLE.
    always_comb begin
        tbl_wr_s = bus.tbl_we && (state_q != ST_RUN);
        for (int i = 0; i < N; i++) begin
            if (tbl_wr_s && (bus.tbl_idx == IW'(i))) begin
                tbl_addr_d[i]  = bus.tbl_addr;
                tbl_off_d[i]   = bus.tbl_off;
                tbl_valid_d[i] = 1'b1;
            end else begin
                tbl_addr_d[i]  = tbl_addr_q[i];
                tbl_off_d[i]   = tbl_off_q[i];
                tbl_valid_d[i] = tbl_valid_q[i];
            end
        end
    end

    // State, datapath, table and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= {D{1'b0}};
            icount_q    <= {CW{1'b0}};
            miss_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tbl_valid_q <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                tbl_addr_q[i] <= {D{1'b0}};
                tbl_off_q[i]  <= {D{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            icount_q    <= icount_d;
            miss_q      <= miss_d;
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            tbl_valid_q <= tbl_valid_d;
            for (int i = 0; i < N; i++) begin
                tbl_addr_q[i] <= tbl_addr_d[i];
                tbl_off_q[i]  <= tbl_off_d[i];
            end
        end
    end

    assign bus.pc     = pc_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.miss   = miss_q;
    assign bus.icount = icount_q;

endmodule
